// File: rtl/display_pkg.sv
// display_pkg: shared constants and FSM encoding for the HEX display formatter
package display_pkg;
  localparam logic [4:0] BLANK_CODE  = 5'h10;
  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DIGITS = 2'd3;
  localparam int CTRL_LZB = 0;
  localparam int CTRL_HEX = 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/dd_add3.sv
// dd_add3: double-dabble nibble correction (nib >= 5 ? nib + 3 : nib)
//   nib : BCD nibble before the shift
//   adj : corrected nibble
module dd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = nib >= 4'd5 ? nib + 4'd3 : nib;
endmodule

// File: rtl/bcd_digit_formatter.sv
// bcd_digit_formatter: Avalon-MM slave turning a binary value into seven-segment digit codes
//   clk, reset         : clock, async active-high reset
//   address/chipselect/write/writedata/read/readdata : Avalon-MM slave (VALUE, CTRL, STATUS, DIGITS)
//   digit_codes        : 5-bit code per digit, digit 0 in [4:0]; 5'h10 blanks a digit
//   busy               : decimal conversion running
module bcd_digit_formatter
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic [5*NUM_DIGITS-1:0] digit_codes,
  output logic                    busy
);
  localparam int ND = NUM_DIGITS;
  localparam int BW = BIN_WIDTH;
  localparam int BCDW = 4 * ND;
  localparam int CW = $clog2(BW + 1);
  localparam logic [31:0] DEC_MAX = 32'(10 ** ND - 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [BCDW-1:0] bcd, adj, src;
  logic [BW-1:0] bin, value_q;
  logic [1:0] ctrl_q;
  logic overflow, run_lzb, lzb_sel, seen, value_wr, over_wr;
  logic [5*ND-1:0] fmt;
  logic unused_wd;
  assign value_wr = chipselect && write && address == ADDR_VALUE;
  assign over_wr = !ctrl_q[CTRL_HEX] && 32'(writedata[BW-1:0]) > DEC_MAX;
  assign busy = state == CONV;
  assign unused_wd = ^writedata[31:BW];
  for (genvar g = 0; g < ND; g++) begin : g_add3
    dd_add3 u_add3 (.nib(bcd[4*g+:4]), .adj(adj[4*g+:4]));
  end
  // One formatter serves both paths: hex nibbles straight from the bus on a VALUE
  // write, otherwise the finished BCD result with the LZB flag latched at its start.
  always_comb begin
    src = value_wr ? BCDW'(writedata[BW-1:0]) : bcd;
    lzb_sel = value_wr ? ctrl_q[CTRL_LZB] : run_lzb;
    seen = 1'b0;
    fmt = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      seen = seen || src[4*i+:4] != 4'd0 || i == 0;
      fmt[5*i+:5] = lzb_sel && !seen ? BLANK_CODE : {1'b0, src[4*i+:4]};
    end
  end
  // A VALUE write overrides every transition so the latest value always wins.
  always_comb begin
    state_nxt = state;
    if (value_wr) state_nxt = ctrl_q[CTRL_HEX] || over_wr ? IDLE : CONV;
    else if (state == CONV && cnt == CW'(BW - 1)) state_nxt = DONE;
    else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      digit_codes <= {ND{BLANK_CODE}};
      value_q <= '0;
      ctrl_q <= '0;
      overflow <= 1'b0;
      run_lzb <= 1'b0;
      bcd <= '0;
      bin <= '0;
      cnt <= '0;
    end else begin
      if (chipselect && read)
        readdata <= address == ADDR_VALUE  ? 32'(value_q) :
                    address == ADDR_CTRL   ? 32'(ctrl_q) :
                    address == ADDR_STATUS ? {30'd0, overflow, busy} : 32'(digit_codes);
      if (chipselect && write && address == ADDR_CTRL) ctrl_q <= writedata[1:0];
      if (value_wr) begin
        value_q <= writedata[BW-1:0];
        overflow <= over_wr;
        if (ctrl_q[CTRL_HEX]) digit_codes <= fmt;
        else if (over_wr) digit_codes <= {ND{BLANK_CODE}};
        bcd <= '0;
        bin <= writedata[BW-1:0];
        cnt <= '0;
        run_lzb <= ctrl_q[CTRL_LZB];
      end else if (state == CONV) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt <= cnt + CW'(1);
      end else if (state == DONE) digit_codes <= fmt;
    end
  end
endmodule

// File: tb/tb_bcd_digit_formatter.sv
// tb_bcd_digit_formatter: randomized self-checking bench against an arithmetic digit model
module tb_bcd_digit_formatter;
  localparam logic [29:0] ALL_BLANK = {6{5'h10}};
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] address = '0;
  logic chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [29:0] digit_codes;
  logic busy;
  int vectors = 0, miscompares = 0;
  logic [29:0] exp_q;
  logic [1:0] ctrl_m;
  logic [19:0] last_v;
  logic [31:0] rd, rd_prev;

  bcd_digit_formatter dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .digit_codes(digit_codes), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] model(input logic [19:0] v, input logic hex, input logic lzb);
    int unsigned d[6];
    int unsigned p;
    int top;
    logic [29:0] r;
    if (!hex && v > 999999) return ALL_BLANK;
    p = 1;
    top = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = hex ? (32'(v) >> (4 * i)) & 15 : (32'(v) / p) % 10;
      p = p * 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < 6; i++) r[5*i+:5] = (lzb && i > top) ? 5'h10 : 5'(d[i]);
    return r;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
    @(negedge clk);
    chipselect = cs; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic set_ctrl(input logic [1:0] c);
    bus_write(2'd1, {30'd0, c}, 1'b1);
    ctrl_m = c;
  endtask

  task automatic put_value(input logic [31:0] v);
    logic [29:0] e;
    logic [31:0] r;
    int n;
    e = model(v[19:0], ctrl_m[1], ctrl_m[0]);
    bus_write(2'd0, v, 1'b1);
    last_v = v[19:0];
    if (ctrl_m[1] || v[19:0] > 999999) begin
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("codes_now", {2'd0, digit_codes}, {2'd0, e});
    end else begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("busy_cycles", n, 32'd20);
      chk("codes_hold", {2'd0, digit_codes}, {2'd0, exp_q});
      @(negedge clk);
      chk("codes_pub", {2'd0, digit_codes}, {2'd0, e});
    end
    exp_q = e;
    bus_read(2'd2, r);
    chk("status", r, {30'd0, !ctrl_m[1] && v[19:0] > 999999, 1'b0});
    bus_read(2'd0, r);
    chk("value_rb", r, {12'd0, v[19:0]});
  endtask

  initial begin
    logic [29:0] e;
    int n;
    exp_q = ALL_BLANK;
    ctrl_m = 2'd0;
    last_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_codes", {2'd0, digit_codes}, {2'd0, ALL_BLANK});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset = 1'b0;

    set_ctrl(2'd1);
    put_value(32'd1234);
    put_value(32'd0);
    bus_read(2'd3, rd);
    chk("digits_rd", rd, {2'd0, exp_q});

    set_ctrl(2'd2);
    put_value(32'hABCDE);
    set_ctrl(2'd3);
    put_value(32'h0ABCD);

    set_ctrl(2'd0);
    put_value(32'd1000000);
    put_value(32'd999999);

    bus_write(2'd0, 32'd555555, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("no_partial", {2'd0, digit_codes}, {2'd0, exp_q});
    end
    put_value(32'd42);

    set_ctrl(2'd1);
    e = model(20'd7, 1'b0, 1'b1);
    bus_write(2'd0, 32'd7, 1'b1);
    bus_write(2'd1, 32'd0, 1'b1);
    ctrl_m = 2'd0;
    last_v = 20'd7;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("ctrl_latched", {2'd0, digit_codes}, {2'd0, e});
    exp_q = e;

    bus_write(2'd0, 32'd123, 1'b0);
    bus_write(2'd1, 32'd3, 1'b0);
    repeat (25) @(negedge clk);
    chk("nocs_busy", {31'd0, busy}, 32'd0);
    chk("nocs_codes", {2'd0, digit_codes}, {2'd0, exp_q});
    bus_read(2'd1, rd);
    chk("nocs_ctrl", rd, {30'd0, ctrl_m});
    bus_read(2'd0, rd_prev);
    chk("nocs_value", rd_prev, {12'd0, last_v});
    @(negedge clk);
    chipselect = 1'b0; read = 1'b1; address = 2'd3;
    @(negedge clk);
    read = 1'b0;
    chk("nocs_read", readdata, rd_prev);

    for (int k = 0; k < 40; k++) begin
      int unsigned sel;
      logic [31:0] v;
      set_ctrl(2'($urandom_range(0, 3)));
      sel = $urandom_range(0, 3);
      v = sel == 0 ? $urandom_range(0, 9) :
          sel == 1 ? $urandom_range(0, 999999) :
          sel == 2 ? $urandom_range(999990, 1000010) : $urandom;
      put_value(v);
      bus_read(2'd3, rd);
      chk("rand_digits", rd, {2'd0, exp_q});
    end

    set_ctrl(2'd0);
    bus_write(2'd0, 32'd777777, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_codes", {2'd0, digit_codes}, {2'd0, ALL_BLANK});
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd2, rd);
    chk("arst_status", rd, 32'd0);
    bus_read(2'd0, rd);
    chk("arst_value", rd, 32'd0);
    bus_read(2'd1, rd);
    chk("arst_ctrl", rd, 32'd0);
    repeat (30) @(negedge clk);
    chk("arst_nopub", {2'd0, digit_codes}, {2'd0, ALL_BLANK});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
